// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and width helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Burst counter must be able to hold MAX_BURST itself, not just MAX_BURST-1.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    function automatic int ptr_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational rotate-priority one-hot picker
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    always_comb begin
        logic        found;
        logic [PW:0] sum;
        logic [PW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        // Scan from ptr upward, wrapping at NREQ so non-power-of-two counts work.
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DATASIZE  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*DATASIZE-1:0] data_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [NREQ-1:0]          grant_o,
    input  logic                     fifo_full_i,
    output logic                     wen_o,
    output logic [DATASIZE-1:0]      din_o,
    output logic                     busy_o
);

    localparam int CW = burst_cnt_width(MAX_BURST);
    localparam int PW = ptr_width(NREQ);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST);

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]     pick;
    logic [PW-1:0]       g_idx, g_next;
    logic [DATASIZE-1:0] g_data;
    logic                req_g, xfer;

    fifo_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick)
    );

    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                g_idx  = PW'(k);
                g_data = data_i[k*DATASIZE +: DATASIZE];
            end
        end
        g_next = (g_idx == PW'(NREQ-1)) ? '0 : g_idx + PW'(1);
    end

    // Reset gates the transfer so nothing reaches the FIFO mid-burst during reset.
    assign req_g   = |(req_i & grant_q);
    assign xfer    = (state_q == BURST) && req_g && !fifo_full_i && !rst_i;
    assign wen_o   = xfer;
    assign ack_o   = xfer ? grant_q : '0;
    assign din_o   = xfer ? g_data : '0;
    assign grant_o = grant_q;
    assign busy_o  = (state_q == BURST) && !rst_i;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!req_g || (xfer && cnt_d == LAST_CNT)) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = g_next;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*DW-1:0] data_i;
    logic [NREQ-1:0]   ack_o;
    logic [NREQ-1:0]   grant_o;
    logic              fifo_full_i;
    logic              wen_o;
    logic [DW-1:0]     din_o;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DATASIZE  (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .grant_o     (grant_o),
        .fifo_full_i (fifo_full_i),
        .wen_o       (wen_o),
        .din_o       (din_o),
        .busy_o      (busy_o)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0] src_base [NREQ];
    int         src_len  [NREQ];
    int         src_pos  [NREQ];

    logic            cap_wen, cap_busy;
    logic [NREQ-1:0] cap_ack, cap_grant;
    logic [DW-1:0]   cap_din;
    int              wen_count = 0;

    logic full_force = 1'b0;
    bit   use_model  = 1'b0;
    logic [9:0] fifo_q [$];
    logic [9:0] rd_q [$];
    int   wr_while_full = 0;
    int   rd_div = 0;

    task automatic apply_inputs();
        for (int k = 0; k < NREQ; k++) begin
            req_i[k] = (src_pos[k] < src_len[k]);
            data_i[k*DW +: DW] = req_i[k] ? src_base[k] + 8'(src_pos[k]) : 8'h00;
        end
        fifo_full_i = use_model ? (fifo_q.size() >= DEPTH) : full_force;
    endtask

    task automatic tick();
        @(negedge clk_i);
        cap_wen   = wen_o;
        cap_ack   = ack_o;
        cap_grant = grant_o;
        cap_din   = din_o;
        cap_busy  = busy_o;
        if (cap_wen) wen_count++;
        if (use_model) begin
            if (cap_wen) begin
                if (fifo_q.size() >= DEPTH) wr_while_full++;
                for (int k = 0; k < NREQ; k++)
                    if (cap_ack[k]) fifo_q.push_back({2'(k), cap_din});
            end
            rd_div++;
            if (rd_div == 3) begin
                rd_div = 0;
                if (fifo_q.size() > 0) rd_q.push_back(fifo_q.pop_front());
            end
        end
        @(posedge clk_i);
        #1;
        for (int k = 0; k < NREQ; k++)
            if (cap_ack[k]) src_pos[k]++;
        apply_inputs();
    endtask

    task automatic do_reset();
        use_model  = 1'b0;
        full_force = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            src_base[k] = 8'h00;
            src_len[k]  = 0;
            src_pos[k]  = 0;
        end
        rst_i = 1'b1;
        apply_inputs();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            src_base[k] = 8'h40 + 8'(16*k);
            src_len[k]  = 8;
            src_pos[k]  = 0;
        end
        apply_inputs();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (cap_grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", cap_grant); else passed++;
            checks++; if (cap_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", cap_busy); else passed++;
            checks++; if (cap_wen !== 1'b0 || cap_ack !== 4'b0000 || cap_din !== 8'h00)
                $display("FAIL reset_outputs: got wen=%b ack=%b din=%h expected 0/0000/00", cap_wen, cap_ack, cap_din); else passed++;
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_din;
        do_reset();
        src_base[0] = 8'h10;
        src_len[0]  = 8;
        apply_inputs();
        tick();
        checks++; if (cap_grant !== 4'b0000 || cap_wen !== 1'b0)
            $display("FAIL single_arb_cycle: got grant=%b wen=%b expected 0000/0", cap_grant, cap_wen); else passed++;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 4; w++) begin
                tick();
                exp_din = 8'h10 + 8'(b*4 + w);
                checks++; if (cap_grant !== 4'b0001 || cap_busy !== 1'b1)
                    $display("FAIL single_grant: got grant=%b busy=%b expected 0001/1", cap_grant, cap_busy); else passed++;
                checks++; if (cap_wen !== 1'b1 || cap_ack !== 4'b0001 || cap_din !== exp_din)
                    $display("FAIL single_xfer: got wen=%b ack=%b din=%h expected 1/0001/%h", cap_wen, cap_ack, cap_din, exp_din); else passed++;
            end
            tick();
            checks++; if (cap_grant !== 4'b0000 || cap_wen !== 1'b0 || cap_din !== 8'h00)
                $display("FAIL single_gap: got grant=%b wen=%b din=%h expected 0000/0/00", cap_grant, cap_wen, cap_din); else passed++;
        end
    endtask

    task automatic test_all_four();
        int k;
        logic [3:0] exp_g;
        logic [7:0] exp_din;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            src_base[i] = 8'h40 + 8'(16*i);
            src_len[i]  = 8;
        end
        apply_inputs();
        for (int b = 0; b < 5; b++) begin
            tick();
            checks++; if (cap_grant !== 4'b0000 || cap_wen !== 1'b0)
                $display("FAIL rr_gap: got grant=%b wen=%b expected 0000/0", cap_grant, cap_wen); else passed++;
            k     = b % 4;
            exp_g = 4'(1 << k);
            for (int w = 0; w < 4; w++) begin
                tick();
                exp_din = 8'h40 + 8'(16*k) + 8'((b/4)*4 + w);
                checks++; if (cap_grant !== exp_g || cap_wen !== 1'b1 || cap_ack !== exp_g || cap_din !== exp_din)
                    $display("FAIL rr_burst: got grant=%b wen=%b ack=%b din=%h expected %b/1/%b/%h",
                             cap_grant, cap_wen, cap_ack, cap_din, exp_g, exp_g, exp_din); else passed++;
            end
        end
    endtask

    task automatic test_full_stall();
        int start_cnt;
        do_reset();
        src_base[0] = 8'h30;
        src_len[0]  = 4;
        apply_inputs();
        start_cnt = wen_count;
        tick();
        tick();
        tick();
        checks++; if (cap_wen !== 1'b1 || cap_din !== 8'h31)
            $display("FAIL full_pre: got wen=%b din=%h expected 1/31", cap_wen, cap_din); else passed++;
        full_force = 1'b1;
        apply_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (cap_wen !== 1'b0 || cap_ack !== 4'b0000 || cap_din !== 8'h00)
                $display("FAIL full_stall: got wen=%b ack=%b din=%h expected 0/0000/00", cap_wen, cap_ack, cap_din); else passed++;
            checks++; if (cap_grant !== 4'b0001 || cap_busy !== 1'b1)
                $display("FAIL full_hold: got grant=%b busy=%b expected 0001/1", cap_grant, cap_busy); else passed++;
        end
        full_force = 1'b0;
        apply_inputs();
        tick();
        checks++; if (cap_wen !== 1'b1 || cap_din !== 8'h32)
            $display("FAIL full_resume: got wen=%b din=%h expected 1/32", cap_wen, cap_din); else passed++;
        tick();
        checks++; if (cap_wen !== 1'b1 || cap_din !== 8'h33)
            $display("FAIL full_last: got wen=%b din=%h expected 1/33", cap_wen, cap_din); else passed++;
        for (int c = 0; c < 3; c++) tick();
        checks++; if (cap_grant !== 4'b0000 || cap_busy !== 1'b0)
            $display("FAIL full_end: got grant=%b busy=%b expected 0000/0", cap_grant, cap_busy); else passed++;
        checks++; if (wen_count - start_cnt !== 4)
            $display("FAIL full_total: got %0d writes expected 4", wen_count - start_cnt); else passed++;
    endtask

    task automatic test_drop();
        do_reset();
        src_base[0] = 8'hA0;
        src_len[0]  = 1;
        src_base[3] = 8'hD0;
        src_len[3]  = 4;
        apply_inputs();
        tick();
        tick();
        checks++; if (cap_grant !== 4'b0001 || cap_wen !== 1'b1 || cap_din !== 8'hA0)
            $display("FAIL drop_first: got grant=%b wen=%b din=%h expected 0001/1/a0", cap_grant, cap_wen, cap_din); else passed++;
        tick();
        checks++; if (cap_grant !== 4'b0001 || cap_busy !== 1'b1 || cap_wen !== 1'b0 || cap_ack !== 4'b0000)
            $display("FAIL drop_end: got grant=%b busy=%b wen=%b ack=%b expected 0001/1/0/0000", cap_grant, cap_busy, cap_wen, cap_ack); else passed++;
        tick();
        checks++; if (cap_grant !== 4'b0000 || cap_busy !== 1'b0)
            $display("FAIL drop_idle: got grant=%b busy=%b expected 0000/0", cap_grant, cap_busy); else passed++;
        tick();
        checks++; if (cap_grant !== 4'b1000 || cap_wen !== 1'b1 || cap_din !== 8'hD0)
            $display("FAIL drop_next: got grant=%b wen=%b din=%h expected 1000/1/d0", cap_grant, cap_wen, cap_din); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            src_base[i] = 8'h40 + 8'(16*i);
            src_len[i]  = 8;
        end
        apply_inputs();
        for (int c = 0; c < 6; c++) tick();
        tick();
        checks++; if (cap_grant !== 4'b0010 || cap_din !== 8'h50)
            $display("FAIL rstmid_pre: got grant=%b din=%h expected 0010/50", cap_grant, cap_din); else passed++;
        tick();
        rst_i = 1'b1;
        tick();
        checks++; if (cap_wen !== 1'b0 || cap_ack !== 4'b0000 || cap_din !== 8'h00 || cap_busy !== 1'b0)
            $display("FAIL rstmid_outputs: got wen=%b ack=%b din=%h busy=%b expected 0/0000/00/0", cap_wen, cap_ack, cap_din, cap_busy); else passed++;
        rst_i = 1'b0;
        tick();
        checks++; if (cap_grant !== 4'b0000 || cap_busy !== 1'b0 || cap_wen !== 1'b0)
            $display("FAIL rstmid_idle: got grant=%b busy=%b wen=%b expected 0000/0/0", cap_grant, cap_busy, cap_wen); else passed++;
        tick();
        checks++; if (cap_grant !== 4'b0001 || cap_wen !== 1'b1 || cap_din !== 8'h44)
            $display("FAIL rstmid_first: got grant=%b wen=%b din=%h expected 0001/1/44", cap_grant, cap_wen, cap_din); else passed++;
    endtask

    task automatic test_fifo_model();
        int cyc;
        int errs;
        int nxt [NREQ];
        int k;
        logic [7:0] d;
        do_reset();
        use_model = 1'b1;
        fifo_q.delete();
        rd_q.delete();
        wr_while_full = 0;
        rd_div = 0;
        for (int i = 0; i < NREQ; i++) begin
            src_base[i] = 8'h80 + 8'(16*i);
            src_len[i]  = 6;
            nxt[i]      = 0;
        end
        apply_inputs();
        cyc = 0;
        while (rd_q.size() < 24 && cyc < 800) begin
            tick();
            cyc++;
        end
        checks++; if (rd_q.size() != 24)
            $display("FAIL model_timeout: got %0d words read expected 24", rd_q.size()); else passed++;
        checks++; if (wr_while_full != 0)
            $display("FAIL model_overflow: got %0d writes while full expected 0", wr_while_full); else passed++;
        errs = 0;
        foreach (rd_q[i]) begin
            k = int'(rd_q[i][9:8]);
            d = rd_q[i][7:0];
            if (d != src_base[k] + 8'(nxt[k])) errs++;
            nxt[k]++;
        end
        checks++; if (errs != 0)
            $display("FAIL model_order: got %0d out-of-order words expected 0", errs); else passed++;
        for (int i = 0; i < NREQ; i++) begin
            checks++; if (nxt[i] != 6)
                $display("FAIL model_count: requester %0d got %0d words expected 6", i, nxt[i]); else passed++;
        end
        use_model = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_i       = '0;
        data_i      = '0;
        fifo_full_i = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            src_base[k] = 8'h00;
            src_len[k]  = 0;
            src_pos[k]  = 0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_fifo_model();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
